// File: rtl/dmem_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : dmem_uart_tx
// Brief    : Memory-mapped 8N1 UART transmitter with a 16-deep TX FIFO.
//            Registers: 0x0 TXDATA (wo), 0x4 STATUS, 0x8 DIVISOR, 0xC rsvd.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_uart_tx #(
  parameter logic [31:0] BASE      = 32'h1000_0010,
  parameter logic [15:0] DIV_RESET = 16'd433,
  parameter int          FIFO_AW   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dmem_rd_addr,
  input  logic        dmem_rd_req,
  output logic [31:0] dmem_rd_data,
  output logic        dmem_rd_ack,
  input  logic [31:0] dmem_wr_addr,
  input  logic [31:0] dmem_wr_data,
  input  logic [3:0]  dmem_wr_be,
  input  logic        dmem_wr_req,
  output logic        tx
);

  localparam int                 c_depth   = 1 << FIFO_AW;
  localparam logic [FIFO_AW-1:0] c_ptr_one = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   c_cnt_one = (FIFO_AW + 1)'(1);

  localparam logic [1:0] c_off_txdata = 2'd0;
  localparam logic [1:0] c_off_status = 2'd1;
  localparam logic [1:0] c_off_div    = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Register state
  // --------------------------------------------------------------------------
  logic [7:0]         r_mem [c_depth];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_overflow;
  logic [15:0]        r_div;

  state_t             r_state;
  state_t             w_state_next;
  logic [7:0]         r_shifter;
  logic [7:0]         w_shifter_next;
  logic [2:0]         r_bit_cnt;
  logic [2:0]         w_bit_cnt_next;
  logic [15:0]        r_baud_cnt;
  logic [15:0]        w_baud_cnt_next;
  logic [15:0]        r_div_lat;
  logic [15:0]        w_div_lat_next;
  logic               r_tx;
  logic               w_tx_next;

  // --------------------------------------------------------------------------
  // Address decode and derived status
  // --------------------------------------------------------------------------
  logic       w_rd_hit;
  logic       w_wr_hit;
  logic [1:0] w_rd_off;
  logic [1:0] w_wr_off;
  logic       w_full;
  logic       w_empty;
  logic       w_busy;
  logic       w_pop;
  logic       w_push_req;
  logic       w_push_ok;
  logic       w_ovf_set;
  logic       w_ovf_clr;
  logic       w_bit_end;
  logic [31:0] w_status;
  logic [31:0] w_rd_value;

  assign w_rd_hit = (dmem_rd_addr[31:4] == BASE[31:4]);
  assign w_wr_hit = (dmem_wr_addr[31:4] == BASE[31:4]);
  assign w_rd_off = dmem_rd_addr[3:2];
  assign w_wr_off = dmem_wr_addr[3:2];

  // Count reaches exactly 2**FIFO_AW when full, so its MSB alone flags full.
  assign w_full  = r_count[FIFO_AW];
  assign w_empty = (r_count == '0);
  assign w_busy  = !w_empty || (r_state != S_IDLE);

  assign w_push_req = dmem_wr_req && w_wr_hit && (w_wr_off == c_off_txdata) && dmem_wr_be[0];
  // A full FIFO still takes the byte when the transmitter pops in the same cycle.
  assign w_push_ok  = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && !w_push_ok;
  assign w_ovf_clr  = dmem_wr_req && w_wr_hit && (w_wr_off == c_off_status) &&
                      dmem_wr_be[0] && dmem_wr_data[3];

  assign w_bit_end = (r_baud_cnt == r_div_lat);

  // Low address bits and unused write lanes are don't-care by design.
  logic w_unused;
  assign w_unused = &{1'b0, dmem_rd_addr[1:0], dmem_wr_addr[1:0],
                      dmem_wr_data[31:16], dmem_wr_be[3:2]};

  // Assemble STATUS word from live register state
  always_comb begin
    w_status                   = 32'd0;
    w_status[0]                = w_full;
    w_status[1]                = w_empty;
    w_status[2]                = w_busy;
    w_status[3]                = r_overflow;
    w_status[8 +: FIFO_AW + 1] = r_count;
  end

  // Read mux; values reflect state before any same-cycle write lands
  always_comb begin
    w_rd_value = 32'd0;
    case (w_rd_off)
      c_off_status: w_rd_value = w_status;
      c_off_div:    w_rd_value = {16'd0, r_div};
      default:      w_rd_value = 32'd0;
    endcase
  end

  // Registered read response, zero when not acknowledged
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_rd_ack  <= 1'b0;
      dmem_rd_data <= 32'd0;
    end else begin
      dmem_rd_ack  <= dmem_rd_req && w_rd_hit;
      dmem_rd_data <= (dmem_rd_req && w_rd_hit) ? w_rd_value : 32'd0;
    end
  end

  // Divisor register with per-byte-lane writes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= DIV_RESET;
    end else if (dmem_wr_req && w_wr_hit && (w_wr_off == c_off_div)) begin
      if (dmem_wr_be[0]) r_div[7:0]  <= dmem_wr_data[7:0];
      if (dmem_wr_be[1]) r_div[15:8] <= dmem_wr_data[15:8];
    end
  end

  // Sticky overflow flag; a set in the same cycle beats a clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (w_ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset because count gates validity
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= dmem_wr_data[7:0];
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Transmitter state register and registered serial output
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shifter  <= 8'd0;
      r_bit_cnt  <= 3'd0;
      r_baud_cnt <= 16'd0;
      r_div_lat  <= 16'd0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_shifter  <= w_shifter_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_baud_cnt <= w_baud_cnt_next;
      r_div_lat  <= w_div_lat_next;
      r_tx       <= w_tx_next;
    end
  end

  // Transmitter next-state: framing, bit timing and FIFO pops
  always_comb begin
    w_state_next    = r_state;
    w_shifter_next  = r_shifter;
    w_bit_cnt_next  = r_bit_cnt;
    w_baud_cnt_next = r_baud_cnt + 16'd1;
    w_div_lat_next  = r_div_lat;
    w_pop           = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_baud_cnt_next = 16'd0;
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_shifter_next = r_mem[r_rd_ptr];
          w_div_lat_next = r_div;
          w_state_next   = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_cnt_next = 16'd0;
          w_bit_cnt_next  = 3'd0;
          w_state_next    = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_cnt_next = 16'd0;
          w_shifter_next  = {1'b0, r_shifter[7:1]};
          w_bit_cnt_next  = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_cnt_next = 16'd0;
          // Chain straight into the next frame when data is waiting.
          if (!w_empty) begin
            w_pop          = 1'b1;
            w_shifter_next = r_mem[r_rd_ptr];
            w_div_lat_next = r_div;
            w_state_next   = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shifter_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  assign tx = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_dmem_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_uart_tx
// Brief    : Directed self-checking bench for dmem_uart_tx. Read responses and
//            per-clock tx levels are predicted into queues and popped on
//            arrival.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_uart_tx;

  localparam logic [31:0] c_base    = 32'h1000_0010;
  localparam logic [15:0] c_div_rst = 16'd433;
  localparam logic [31:0] c_txdata  = c_base + 32'h0;
  localparam logic [31:0] c_status  = c_base + 32'h4;
  localparam logic [31:0] c_divisor = c_base + 32'h8;
  localparam logic [31:0] c_rsvd    = c_base + 32'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dmem_rd_addr;
  logic        dmem_rd_req;
  logic [31:0] dmem_rd_data;
  logic        dmem_rd_ack;
  logic [31:0] dmem_wr_addr;
  logic [31:0] dmem_wr_data;
  logic [3:0]  dmem_wr_be;
  logic        dmem_wr_req;
  logic        tx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd_q[$];
  logic        tx_q[$];

  dmem_uart_tx #(
    .BASE      (c_base),
    .DIV_RESET (c_div_rst),
    .FIFO_AW   (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dmem_rd_addr (dmem_rd_addr),
    .dmem_rd_req  (dmem_rd_req),
    .dmem_rd_data (dmem_rd_data),
    .dmem_rd_ack  (dmem_rd_ack),
    .dmem_wr_addr (dmem_wr_addr),
    .dmem_wr_data (dmem_wr_data),
    .dmem_wr_be   (dmem_wr_be),
    .dmem_wr_req  (dmem_wr_req),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Single-cycle write, called and returning on a falling edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    dmem_wr_addr = addr;
    dmem_wr_data = data;
    dmem_wr_be   = be;
    dmem_wr_req  = 1'b1;
    @(negedge clk);
    dmem_wr_req  = 1'b0;
  endtask

  // Read expected to hit: prediction queued at issue, compared on ack.
  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    dmem_rd_addr = addr;
    dmem_rd_req  = 1'b1;
    rd_q.push_back(exp);
    @(negedge clk);
    dmem_rd_req  = 1'b0;
    check({tag, "_ack"}, {31'd0, dmem_rd_ack}, 32'd1);
    check(tag, dmem_rd_data, rd_q.pop_front());
  endtask

  task automatic rd_miss(input string tag, input logic [31:0] addr);
    dmem_rd_addr = addr;
    dmem_rd_req  = 1'b1;
    @(negedge clk);
    dmem_rd_req  = 1'b0;
    check({tag, "_ack"}, {31'd0, dmem_rd_ack}, 32'd0);
    check(tag, dmem_rd_data, 32'd0);
  endtask

  task automatic push_level(input logic lvl, input int n);
    for (int i = 0; i < n; i++) tx_q.push_back(lvl);
  endtask

  // Predict one 8N1 frame at (div+1) clocks per bit.
  task automatic push_frame(input logic [7:0] b, input int div);
    push_level(1'b0, div + 1);
    for (int i = 0; i < 8; i++) push_level(b[i], div + 1);
    push_level(1'b1, div + 1);
  endtask

  // Compare tx at the current falling edge and the following n-1 ones.
  task automatic check_tx(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, {31'd0, tx}, {31'd0, tx_q.pop_front()});
      @(negedge clk);
    end
  endtask

  initial begin
    reset        = 1'b1;
    dmem_rd_addr = 32'd0;
    dmem_rd_req  = 1'b0;
    dmem_wr_addr = 32'd0;
    dmem_wr_data = 32'd0;
    dmem_wr_be   = 4'd0;
    dmem_wr_req  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tx",   {31'd0, tx}, 32'd1);
    check("rst_ack",  {31'd0, dmem_rd_ack}, 32'd0);
    check("rst_data", dmem_rd_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Register reads after reset, including a miss just below the window
    rd("div_rst", c_divisor, {16'd0, c_div_rst});
    rd_miss("miss", 32'h1000_0000);
    rd("txdata_rd", c_txdata, 32'd0);
    rd("rsvd_rd",   c_rsvd,   32'd0);
    rd("status_rst", c_status, 32'h2);

    // TXDATA write without byte lane 0 must be ignored
    wr(c_txdata, 32'h11, 4'b1110);
    rd("be0_ignored", c_status, 32'h2);

    // Divisor byte-lane writes
    wr(c_divisor, 32'h0000_AB00, 4'b0010);
    rd("div_lane1", c_divisor, 32'h0000_ABB1);
    wr(c_divisor, 32'hFFFF_0003, 4'b0011);
    rd("div_3", c_divisor, 32'h0000_0003);

    // One 0xA5 frame at div=3: 40 clocks then idle
    wr(c_txdata, 32'hA5, 4'b0001);
    push_level(1'b1, 1);
    push_frame(8'hA5, 3);
    push_level(1'b1, 2);
    check_tx("tx_a5", 43);
    rd("status_after_a5", c_status, 32'h2);

    // Back-to-back frames at div=0 with no idle gap
    wr(c_divisor, 32'h0, 4'b0011);
    dmem_wr_addr = c_txdata;
    dmem_wr_data = 32'h55;
    dmem_wr_be   = 4'b0001;
    dmem_wr_req  = 1'b1;
    @(negedge clk);
    dmem_wr_data = 32'h0F;
    @(negedge clk);
    dmem_wr_req  = 1'b0;
    push_frame(8'h55, 0);
    push_frame(8'h0F, 0);
    push_level(1'b1, 2);
    check_tx("tx_b2b", 22);
    rd("status_after_b2b", c_status, 32'h2);

    // STATUS read alongside a push into an empty FIFO sees the pre-push state
    dmem_wr_addr = c_txdata;
    dmem_wr_data = 32'h3C;
    dmem_wr_be   = 4'b0001;
    dmem_wr_req  = 1'b1;
    dmem_rd_addr = c_status;
    dmem_rd_req  = 1'b1;
    rd_q.push_back(32'h2);
    @(negedge clk);
    dmem_wr_req  = 1'b0;
    dmem_rd_req  = 1'b0;
    check("same_cycle_ack", {31'd0, dmem_rd_ack}, 32'd1);
    check("same_cycle_status", dmem_rd_data, rd_q.pop_front());
    push_level(1'b1, 1);
    push_frame(8'h3C, 0);
    push_level(1'b1, 1);
    check_tx("tx_3c", 12);

    // Reset during DATA bit 3 aborts the frame and drops the queued byte
    dmem_wr_addr = c_txdata;
    dmem_wr_data = 32'h00;
    dmem_wr_be   = 4'b0001;
    dmem_wr_req  = 1'b1;
    @(negedge clk);
    dmem_wr_data = 32'h7E;
    @(negedge clk);
    dmem_wr_req  = 1'b0;
    check("abort_start", {31'd0, tx}, 32'd0);
    repeat (4) @(negedge clk);
    check("abort_bit3", {31'd0, tx}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_tx_high", {31'd0, tx}, 32'd1);
    reset = 1'b0;
    rd("abort_status", c_status, 32'h2);
    rd("abort_div", c_divisor, {16'd0, c_div_rst});
    push_level(1'b1, 20);
    check_tx("abort_idle", 20);

    // Fill the FIFO at div=0xFFFF, then overflow and clear
    wr(c_divisor, 32'h0000_FFFF, 4'b0011);
    dmem_wr_addr = c_txdata;
    dmem_wr_be   = 4'b0001;
    dmem_wr_req  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      dmem_wr_data = 32'(i + 1);
      @(negedge clk);
    end
    dmem_wr_req  = 1'b0;
    rd("fifo_full", c_status, 32'h1005);
    check("full_tx_start", {31'd0, tx}, 32'd0);
    wr(c_txdata, 32'hEE, 4'b0001);
    rd("overflow_set", c_status, 32'h100D);
    wr(c_status, 32'h7, 4'b0001);
    rd("overflow_kept", c_status, 32'h100D);
    wr(c_status, 32'h8, 4'b0001);
    rd("overflow_clr", c_status, 32'h1005);

    // Final reset empties everything
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("final_tx", {31'd0, tx}, 32'd1);
    rd("final_status", c_status, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
